// File: rtl/dmi_uart_bridge.sv
// dmi_uart_bridge: buffered bridge from the UART-TAP to the Debug Module's
// ready-valid DMI bus. TAP requests queue in a small FIFO and are issued to
// the DM one at a time; completed operations update a response register that
// the TAP reads back with a DMI error code.
// Optional feature: define DMI_UART_BRIDGE_TIMEOUT_EN to abort DM transactions
// that take TIMEOUT_CYCLES cycles and report them as failed.
//
// state | meaning
// IDLE  | no DM transaction; pop the FIFO head when one is queued
// REQ   | request presented to the DM, waiting for DMI_REQ_READY_I
// RESP  | READ accepted by the DM, waiting for DMI_RESP_VALID_I
module dmi_uart_bridge #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic                             TAP_WRITE_VALID_I,
  output logic                             TAP_WRITE_READY_O,
  input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] TAP_WRITE_DATA_I,
  input  logic                             TAP_READ_READY_I,
  output logic                             TAP_READ_VALID_O,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] TAP_READ_DATA_O,
  output logic                             DMI_REQ_VALID_O,
  input  logic                             DMI_REQ_READY_I,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] DMI_REQ_O,
  input  logic                             DMI_RESP_VALID_I,
  output logic                             DMI_RESP_READY_O,
  input  logic [DATA_WIDTH+1:0]            DMI_RESP_I
);
  localparam int W     = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // TAP and DM op encodings coincide, so requests pass through unchanged
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_FAIL = 2'd2;
  localparam logic [1:0] ERR_BUSY = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           fifo_mem_q [REQ_DEPTH];
  logic [W-1:0]           fifo_mem_d [REQ_DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [W-1:0]           req_q, req_d;
  logic                   req_valid_q, req_valid_d;
  logic                   resp_ready_q, resp_ready_d;
  logic [ADDR_WIDTH-1:0]  resp_addr_q, resp_addr_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   failed_q, failed_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [W-1:0]           rd_data_q, rd_data_d;

  logic       full, empty, push, pop, busy, fail_set, dm_done, tmo_fail;
  logic [1:0] tap_op;

  assign full              = (count_q == CNT_W'(REQ_DEPTH));
  assign empty             = (count_q == '0);
  assign TAP_WRITE_READY_O = !full && !RST_I;
  assign tap_op            = TAP_WRITE_DATA_I[1:0];
  // NOP and reserved ops complete the handshake but are never queued
  assign push    = TAP_WRITE_VALID_I && TAP_WRITE_READY_O
                   && (tap_op == OP_READ || tap_op == OP_WRITE);
  assign pop     = (state_q == IDLE) && !empty;
  assign busy    = (state_q != IDLE) || !empty;
  assign dm_done = (state_q == REQ && DMI_REQ_READY_I)
                   || (state_q == RESP && DMI_RESP_VALID_I);

`ifdef DMI_UART_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Per-transaction cycle counter, restarted whenever the state changes
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q)  tmo_cnt_d = '0;
    else if (state_q != IDLE) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // A DM handshake landing on the terminal cycle still completes normally
  assign tmo_fail = (state_q != IDLE) && !dm_done
                    && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_fail       = 1'b0;
`endif

  // Request FIFO next-state
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wptr_q] = TAP_WRITE_DATA_I;
      wptr_d             = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Issue FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = REQ;
      REQ:     if (DMI_REQ_READY_I) state_d = (req_q[1:0] == OP_READ) ? RESP : IDLE;
      RESP:    if (DMI_RESP_VALID_I) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_fail) state_d = IDLE;
  end

  // Registered outputs, response register and sticky failed flag
  always_comb begin
    req_valid_d  = (state_d == REQ);
    resp_ready_d = (state_d == RESP);
    req_d        = pop ? fifo_mem_q[rptr_q] : req_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    fail_set     = tmo_fail;
    if (state_q == REQ && DMI_REQ_READY_I && req_q[1:0] == OP_WRITE)
      resp_addr_d = req_q[W-1 -: ADDR_WIDTH];
    if (state_q == RESP && DMI_RESP_VALID_I) begin
      resp_addr_d = req_q[W-1 -: ADDR_WIDTH];
      resp_data_d = DMI_RESP_I[DATA_WIDTH+1:2];
      if (DMI_RESP_I[1:0] != 2'd0) fail_set = 1'b1;
    end
    rd_valid_d = TAP_READ_READY_I && !rd_valid_q;
    rd_data_d  = rd_data_q;
    failed_d   = failed_q;
    if (rd_valid_d) begin
      rd_data_d = {resp_addr_q, resp_data_q,
                   failed_q ? ERR_FAIL : (busy ? ERR_BUSY : ERR_NONE)};
      failed_d  = 1'b0;
    end
    // A new failure outranks the clear of a failure being reported now
    if (fail_set) failed_d = 1'b1;
  end

  // State, FIFO and output registers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q      <= IDLE;
      for (int i = 0; i < REQ_DEPTH; i++) fifo_mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      failed_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fifo_mem_q   <= fifo_mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      failed_q     <= failed_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign DMI_REQ_VALID_O  = req_valid_q;
  assign DMI_REQ_O        = req_q;
  assign DMI_RESP_READY_O = resp_ready_q;
  assign TAP_READ_VALID_O = rd_valid_q;
  assign TAP_READ_DATA_O  = rd_data_q;
endmodule

// File: tb/tb_dmi_uart_bridge.sv
// Directed bench for dmi_uart_bridge with default widths and REQ_DEPTH=4.
module tb_dmi_uart_bridge;
  localparam int W = 41;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tw_valid = 1'b0;
  logic          tw_ready;
  logic [W-1:0]  tw_data = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          dmi_req_valid;
  logic          dmi_req_ready = 1'b0;
  logic [W-1:0]  dmi_req;
  logic          dmi_resp_valid = 1'b0;
  logic          dmi_resp_ready;
  logic [33:0]   dmi_resp = '0;

  int n_chk  = 0;
  int n_pass = 0;

  dmi_uart_bridge #(
    .ADDR_WIDTH(7), .DATA_WIDTH(32), .REQ_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK_I(clk), .RST_I(rst),
    .TAP_WRITE_VALID_I(tw_valid), .TAP_WRITE_READY_O(tw_ready),
    .TAP_WRITE_DATA_I(tw_data),
    .TAP_READ_READY_I(rd_ready), .TAP_READ_VALID_O(rd_valid),
    .TAP_READ_DATA_O(rd_data),
    .DMI_REQ_VALID_O(dmi_req_valid), .DMI_REQ_READY_I(dmi_req_ready),
    .DMI_REQ_O(dmi_req),
    .DMI_RESP_VALID_I(dmi_resp_valid), .DMI_RESP_READY_O(dmi_resp_ready),
    .DMI_RESP_I(dmi_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] pk(input logic [6:0] a, input logic [31:0] d,
                                      input logic [1:0] f);
    return {a, d, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tap_write(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    int n = 0;
    tw_valid = 1'b1;
    tw_data  = pk(a, d, op);
    while (!tw_ready && n < 50) begin step(); n++; end
    chk("tw_ready", tw_ready, 1);
    step();
    tw_valid = 1'b0;
  endtask

  task automatic tap_read(input string tag, input logic [W-1:0] exp);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
    step();
    chk({tag, "_pulse_end"}, rd_valid, 0);
  endtask

  task automatic wait_req_valid(input string tag);
    int n = 0;
    while (!dmi_req_valid && n < 20) begin step(); n++; end
    chk(tag, dmi_req_valid, 1);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_tw_ready", tw_ready, 0);
    chk("rst_req_valid", dmi_req_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_tw_ready", tw_ready, 1);

    // first-request latency and READ round trip
    tap_write(7'h11, 32'h0, 2'd1);
    chk("lat_cycle1", dmi_req_valid, 0);
    step();
    chk("lat_cycle2", dmi_req_valid, 1);
    chk("read_req", dmi_req, pk(7'h11, 32'h0, 2'd1));
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    chk("read_req_drop", dmi_req_valid, 0);
    chk("read_resp_ready", dmi_resp_ready, 1);
    dmi_resp_valid = 1'b1;
    dmi_resp = {32'hDEADBEEF, 2'd0};
    step();
    dmi_resp_valid = 1'b0;
    chk("read_resp_ready_drop", dmi_resp_ready, 0);
    tap_read("read", pk(7'h11, 32'hDEADBEEF, 2'd0));

    // fill FIFO behind a stalled DM, then drain in order
    for (int i = 0; i < 5; i++) tap_write(7'h20 + 7'(i), 32'h1000 + i, 2'd2);
    chk("full_tw_ready", tw_ready, 0);
    chk("full_head", dmi_req, pk(7'h20, 32'h1000, 2'd2));
    tap_read("busy", pk(7'h11, 32'hDEADBEEF, 2'd3));
    dmi_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", dmi_req_valid, 1);
      chk("drain_req", dmi_req, pk(7'h20 + 7'(i), 32'h1000 + i, 2'd2));
      step();
      chk("drain_gap", dmi_req_valid, 0);
      step();
    end
    dmi_req_ready = 1'b0;
    chk("drained_valid", dmi_req_valid, 0);
    tap_read("after_drain", pk(7'h24, 32'hDEADBEEF, 2'd0));

    // NOP and reserved ops are swallowed
    tap_write(7'h55, 32'h1, 2'd0);
    tap_write(7'h56, 32'h2, 2'd3);
    step(); step();
    chk("nop_no_req", dmi_req_valid, 0);
    tap_read("nop_idle", pk(7'h24, 32'hDEADBEEF, 2'd0));

    // failed response is sticky until reported once
    tap_write(7'h33, 32'h0, 2'd1);
    wait_req_valid("fail_req_valid");
    tap_read("busy_inflight", pk(7'h24, 32'hDEADBEEF, 2'd3));
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    chk("fail_resp_ready", dmi_resp_ready, 1);
    dmi_resp_valid = 1'b1;
    dmi_resp = {32'hCAFEF00D, 2'd2};
    step();
    dmi_resp_valid = 1'b0;
    tap_read("failed", pk(7'h33, 32'hCAFEF00D, 2'd2));
    tap_read("fail_cleared", pk(7'h33, 32'hCAFEF00D, 2'd0));

    // READY held high gives one pulse every two cycles
    rd_ready = 1'b1;
    step(); chk("hold_p0", rd_valid, 1);
    step(); chk("hold_p1", rd_valid, 0);
    step(); chk("hold_p2", rd_valid, 1);
    rd_ready = 1'b0;
    step(); chk("hold_p3", rd_valid, 0);

    // reset while waiting on a READ response
    tap_write(7'h44, 32'h0, 2'd1);
    wait_req_valid("mid_req_valid");
    tap_write(7'h45, 32'h1, 2'd2);
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    chk("mid_in_resp", dmi_resp_ready, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_resp_ready", dmi_resp_ready, 0);
    chk("mid_rst_req_valid", dmi_req_valid, 0);
    chk("mid_rst_req", dmi_req, 0);
    chk("mid_rst_tw_ready", tw_ready, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rel_tw_ready", tw_ready, 1);
    step(); step(); step();
    chk("mid_fifo_empty", dmi_req_valid, 0);
    tap_read("mid_resp_cleared", pk(7'h00, 32'h0, 2'd0));

    // DM that never accepts
    tap_write(7'h66, 32'h7, 2'd2);
    wait_req_valid("tmo_req_valid");
`ifdef DMI_UART_BRIDGE_TIMEOUT_EN
    repeat (15) step();
    chk("tmo_still_waiting", dmi_req_valid, 1);
    step();
    chk("tmo_abort", dmi_req_valid, 0);
    tap_read("tmo_failed", pk(7'h00, 32'h0, 2'd2));
`else
    repeat (10000) step();
    chk("no_tmo_waiting", dmi_req_valid, 1);
    chk("no_tmo_req", dmi_req, pk(7'h66, 32'h7, 2'd2));
    tap_read("no_tmo_busy", pk(7'h00, 32'h0, 2'd3));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
